// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, field offsets and flit pack/unpack helpers.
package noc_pkg;

    localparam int FLIT_W   = 20;
    localparam int DATA_W   = 16;
    localparam int DEST_W   = 4;
    localparam int DEST_LSB = 0;
    localparam int DATA_LSB = DEST_W;

    typedef logic [FLIT_W-1:0] flit_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [DEST_W-1:0] dest_t;

    // Flit layout is {data, dest} with the destination in the low nibble.
    function automatic flit_t make_flit(input data_t data, input dest_t dest);
        flit_t f;
        f = '0;
        f[DATA_LSB +: DATA_W] = data;
        f[DEST_LSB +: DEST_W] = dest;
        return f;
    endfunction

    function automatic dest_t flit_dest(input flit_t f);
        return f[DEST_LSB +: DEST_W];
    endfunction

    function automatic data_t flit_data(input flit_t f);
        return f[DATA_LSB +: DATA_W];
    endfunction

endpackage

// File: rtl/ni_tx_if.sv
// Core request channel plus router local-port link (in5/vi5/co5) of the NI transmitter.
interface ni_tx_if;
    import noc_pkg::*;

    // core side
    data_t req_data;
    dest_t req_dest;
    logic  req_valid;
    logic  req_ready;
    // router side
    flit_t o;
    logic  vo;
    logic  ci;

    // master: core issuing requests and router returning credits
    modport master (
        output req_data, req_dest, req_valid, ci,
        input  req_ready, o, vo
    );

    // slave: the transmitter itself
    modport slave (
        input  req_data, req_dest, req_valid, ci,
        output req_ready, o, vo
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered full/empty flags and asynchronous active-high reset.
module sync_fifo
    import noc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = FLIT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    // Qualify operations against current flags and derive next occupancy.
    always_comb begin
        do_push   = push && !full;
        do_pop    = pop && !empty;
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count - (AW+1)'(1);
        end
    end

    // Pointers, occupancy and flags; flags are registered from next occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
        end
    end

    // Storage array; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Head of queue is always presented for look-ahead pop.
    always_comb begin
        dout = mem[rd_ptr];
    end

endmodule

// File: rtl/ni_tx.sv
// NI transmitter: buffers core requests as flits and injects them into the router
// local port under credit-based flow control.
module ni_tx
    import noc_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int CREDITS = 4,
    parameter int CNT_W   = 16,
    localparam int CW     = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             RST,
    input  dest_t            position,
    ni_tx_if.slave           nif,
    output logic [CW-1:0]    credit_cnt,
    output logic [CNT_W-1:0] sent_cnt,
    output logic             loopback,
    output logic             credit_err
);

    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    flit_t head;
    flit_t req_flit;
    logic  fifo_full;
    logic  fifo_empty;
    logic  push;
    logic  send;

    // Request acceptance and issue decision; no pop bypass into a full FIFO.
    always_comb begin
        nif.req_ready = !RST && !fifo_full;
        push          = nif.req_valid && nif.req_ready;
        send          = !fifo_empty && (credit_cnt != '0);
        req_flit      = make_flit(nif.req_data, nif.req_dest);
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FLIT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (RST),
        .push  (push),
        .din   (req_flit),
        .pop   (send),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Output register: one-cycle flit pulse, zeroed when nothing is sent.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            nif.o    <= '0;
            nif.vo   <= 1'b0;
            loopback <= 1'b0;
        end else begin
            nif.o    <= send ? head : '0;
            nif.vo   <= send;
            loopback <= send && (flit_dest(head) == position);
        end
    end

    // Credit tracking; a return while already full is flagged and ignored.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            credit_cnt <= CRED_MAX;
            credit_err <= 1'b0;
        end else begin
            case ({send, nif.ci})
                2'b10: credit_cnt <= credit_cnt - CW'(1);
                2'b01: begin
                    if (credit_cnt == CRED_MAX) begin
                        credit_err <= 1'b1;
                    end else begin
                        credit_cnt <= credit_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Injected-flit statistic, free-running with wrap.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            sent_cnt <= '0;
        end else if (send) begin
            sent_cnt <= sent_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ni_tx.sv
// Self-checking bench for ni_tx against a queue-based transaction model.
module tb_ni_tx;

    logic        clk;
    logic        rst;
    logic [3:0]  position;
    logic [2:0]  credit_cnt;
    logic [3:0]  sent_cnt;
    logic        loopback;
    logic        credit_err;

    ni_tx_if bus ();

    ni_tx #(
        .DEPTH   (4),
        .CREDITS (4),
        .CNT_W   (4)
    ) dut (
        .clk        (clk),
        .RST        (rst),
        .position   (position),
        .nif        (bus),
        .credit_cnt (credit_cnt),
        .sent_cnt   (sent_cnt),
        .loopback   (loopback),
        .credit_err (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec;
    int nerr;

    // reference model state
    logic [19:0] q[$];
    int          m_cred;
    logic [3:0]  m_sent;
    logic        m_err;
    logic [19:0] m_o;
    logic        m_vo;
    logic        m_lb;

    task automatic model_reset();
        q.delete();
        m_cred = 4;
        m_sent = '0;
        m_err  = 1'b0;
        m_o    = '0;
        m_vo   = 1'b0;
        m_lb   = 1'b0;
    endtask

    // Drive one cycle of stimulus, advance the model across the edge, settle #1 after it.
    task automatic step(input bit v, input logic [15:0] d, input logic [3:0] dst, input bit c);
        bit          acc;
        bit          snd;
        logic [19:0] f;
        bus.req_valid = v;
        bus.req_data  = d;
        bus.req_dest  = dst;
        bus.ci        = c;
        acc = v && (q.size() < 4);
        snd = (q.size() > 0) && (m_cred > 0);
        if (snd) begin
            f      = q.pop_front();
            m_o    = f;
            m_vo   = 1'b1;
            m_lb   = (f[3:0] == position);
            m_sent = m_sent + 4'd1;
        end else begin
            m_o  = '0;
            m_vo = 1'b0;
            m_lb = 1'b0;
        end
        if (snd && !c) m_cred = m_cred - 1;
        else if (c && !snd) begin
            if (m_cred == 4) m_err = 1'b1;
            else m_cred = m_cred + 1;
        end
        if (acc) q.push_back({d, dst});
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.ci        = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        nvec++; if (bus.req_ready !== 1'b0) begin nerr++; $display("FAIL reset.req_ready got %b want 0", bus.req_ready); end
        nvec++; if (bus.vo !== 1'b0) begin nerr++; $display("FAIL reset.vo got %b want 0", bus.vo); end
        nvec++; if (bus.o !== 20'h0) begin nerr++; $display("FAIL reset.o got %h want 0", bus.o); end
        nvec++; if (credit_cnt !== 3'd4) begin nerr++; $display("FAIL reset.credit_cnt got %0d want 4", credit_cnt); end
        nvec++; if (sent_cnt !== 4'd0) begin nerr++; $display("FAIL reset.sent_cnt got %0d want 0", sent_cnt); end
        nvec++; if (credit_err !== 1'b0) begin nerr++; $display("FAIL reset.credit_err got %b want 0", credit_err); end
        nvec++; if (loopback !== 1'b0) begin nerr++; $display("FAIL reset.loopback got %b want 0", loopback); end
        #2 rst = 1'b0;
        model_reset();
        #1;
        nvec++; if (bus.req_ready !== 1'b1) begin nerr++; $display("FAIL reset.ready_after got %b want 1", bus.req_ready); end
    endtask

    task automatic test_single();
        step(1'b1, 16'h0001, 4'd10, 1'b0);
        nvec++; if (bus.vo !== 1'b0) begin nerr++; $display("FAIL single.vo_edge1 got %b want 0", bus.vo); end
        step(1'b0, 16'h0, 4'd0, 1'b0);
        nvec++; if (bus.vo !== 1'b1) begin nerr++; $display("FAIL single.vo got %b want 1", bus.vo); end
        nvec++; if (bus.o !== 20'h0001A) begin nerr++; $display("FAIL single.o got %h want 0001a", bus.o); end
        nvec++; if (credit_cnt !== 3'd3) begin nerr++; $display("FAIL single.credit got %0d want 3", credit_cnt); end
        nvec++; if (sent_cnt !== 4'd1) begin nerr++; $display("FAIL single.sent got %0d want 1", sent_cnt); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0, 4'd0, 1'b0);
            nvec++; if (bus.vo !== 1'b0 || bus.o !== 20'h0) begin nerr++; $display("FAIL single.idle vo=%b o=%h want 0/0", bus.vo, bus.o); end
        end
    endtask

    task automatic test_burst();
        do_reset();
        for (int i = 0; i < 13; i++) begin
            if (i < 6) step(1'b1, 16'($urandom), 4'($urandom), 1'b0);
            else if (i == 8 || i == 9) step(1'b0, 16'h0, 4'd0, 1'b1);
            else step(1'b0, 16'h0, 4'd0, 1'b0);
            nvec++; if (bus.vo !== m_vo) begin nerr++; $display("FAIL burst.vo[%0d] got %b want %b", i, bus.vo, m_vo); end
            nvec++; if (bus.o !== m_o) begin nerr++; $display("FAIL burst.o[%0d] got %h want %h", i, bus.o, m_o); end
            nvec++; if (credit_cnt !== 3'(m_cred)) begin nerr++; $display("FAIL burst.credit[%0d] got %0d want %0d", i, credit_cnt, m_cred); end
            nvec++; if (sent_cnt !== m_sent) begin nerr++; $display("FAIL burst.sent[%0d] got %0d want %0d", i, sent_cnt, m_sent); end
            if (i == 7) begin
                nvec++; if (credit_cnt !== 3'd0 || bus.vo !== 1'b0) begin nerr++; $display("FAIL burst.stall credit=%0d vo=%b want 0/0", credit_cnt, bus.vo); end
            end
        end
        nvec++; if (sent_cnt !== 4'd6) begin nerr++; $display("FAIL burst.total got %0d want 6", sent_cnt); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 6; i++) step(i < 4, 16'($urandom), 4'($urandom), 1'b0);
        for (int i = 0; i < 26; i++) begin
            if (i < 8) step(1'b1, 16'($urandom), 4'($urandom), 1'b0);
            else step(1'b0, 16'h0, 4'd0, (i % 2) == 0);
            nvec++; if (bus.req_ready !== (q.size() < 4)) begin nerr++; $display("FAIL fill.ready[%0d] got %b want %b", i, bus.req_ready, q.size() < 4); end
            nvec++; if (bus.vo !== m_vo) begin nerr++; $display("FAIL fill.vo[%0d] got %b want %b", i, bus.vo, m_vo); end
            nvec++; if (bus.o !== m_o) begin nerr++; $display("FAIL fill.o[%0d] got %h want %h", i, bus.o, m_o); end
            nvec++; if (credit_cnt !== 3'(m_cred)) begin nerr++; $display("FAIL fill.credit[%0d] got %0d want %0d", i, credit_cnt, m_cred); end
            if (i == 3) begin
                nvec++; if (bus.req_ready !== 1'b0) begin nerr++; $display("FAIL fill.full got %b want 0", bus.req_ready); end
            end
        end
        nvec++; if (sent_cnt !== 4'd8) begin nerr++; $display("FAIL fill.total got %0d want 8", sent_cnt); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 16'($urandom), 4'($urandom), m_vo);
            nvec++; if (bus.vo !== m_vo) begin nerr++; $display("FAIL stream.vo[%0d] got %b want %b", i, bus.vo, m_vo); end
            nvec++; if (bus.o !== m_o) begin nerr++; $display("FAIL stream.o[%0d] got %h want %h", i, bus.o, m_o); end
            nvec++; if (credit_cnt !== 3'(m_cred)) begin nerr++; $display("FAIL stream.credit[%0d] got %0d want %0d", i, credit_cnt, m_cred); end
            nvec++; if (sent_cnt !== m_sent) begin nerr++; $display("FAIL stream.sent[%0d] got %0d want %0d", i, sent_cnt, m_sent); end
        end
        // 23 flits injected with a 4-bit counter: wrapped once
        nvec++; if (sent_cnt !== 4'd7) begin nerr++; $display("FAIL stream.wrap got %0d want 7", sent_cnt); end
        nvec++; if (credit_err !== 1'b0) begin nerr++; $display("FAIL stream.err got %b want 0", credit_err); end
    endtask

    task automatic test_err_loop();
        do_reset();
        position = 4'd5;
        step(1'b0, 16'h0, 4'd0, 1'b1);
        nvec++; if (credit_cnt !== 3'd4) begin nerr++; $display("FAIL err.credit got %0d want 4", credit_cnt); end
        nvec++; if (credit_err !== 1'b1) begin nerr++; $display("FAIL err.flag got %b want 1", credit_err); end
        step(1'b1, 16'hBEEF, 4'd5, 1'b0);
        step(1'b0, 16'h0, 4'd0, 1'b0);
        nvec++; if (bus.vo !== 1'b1 || loopback !== 1'b1) begin nerr++; $display("FAIL err.loopback vo=%b lb=%b want 1/1", bus.vo, loopback); end
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 16'($urandom), ($urandom_range(0, 1) == 0) ? 4'd5 : 4'($urandom), m_vo);
            nvec++; if (loopback !== m_lb) begin nerr++; $display("FAIL err.lb[%0d] got %b want %b", i, loopback, m_lb); end
            nvec++; if (bus.o !== m_o) begin nerr++; $display("FAIL err.o[%0d] got %h want %h", i, bus.o, m_o); end
            nvec++; if (credit_err !== m_err) begin nerr++; $display("FAIL err.sticky[%0d] got %b want %b", i, credit_err, m_err); end
        end
        position = 4'd0;
    endtask

    task automatic test_rst_mid();
        do_reset();
        for (int i = 0; i < 6; i++) step(i < 4, 16'($urandom), 4'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 16'($urandom), 4'($urandom), 1'b0);
        step(1'b0, 16'h0, 4'd0, 1'b1);
        step(1'b0, 16'h0, 4'd0, 1'b0);
        nvec++; if (bus.vo !== 1'b1 || q.size() != 3) begin nerr++; $display("FAIL rstmid.pre vo=%b buffered=%0d want 1/3", bus.vo, q.size()); end
        #2 rst = 1'b1;
        #1;
        nvec++; if (bus.vo !== 1'b0) begin nerr++; $display("FAIL rstmid.vo got %b want 0", bus.vo); end
        nvec++; if (credit_cnt !== 3'd4) begin nerr++; $display("FAIL rstmid.credit got %0d want 4", credit_cnt); end
        nvec++; if (sent_cnt !== 4'd0) begin nerr++; $display("FAIL rstmid.sent got %0d want 0", sent_cnt); end
        #2 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 16'h0, 4'd0, 1'b0);
            nvec++; if (bus.vo !== 1'b0) begin nerr++; $display("FAIL rstmid.after_vo[%0d] got %b want 0", i, bus.vo); end
            nvec++; if (bus.req_ready !== 1'b1) begin nerr++; $display("FAIL rstmid.ready[%0d] got %b want 1", i, bus.req_ready); end
        end
    endtask

    initial begin
        nvec          = 0;
        nerr          = 0;
        rst           = 1'b1;
        position      = 4'd0;
        bus.req_valid = 1'b0;
        bus.req_data  = '0;
        bus.req_dest  = '0;
        bus.ci        = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_burst();
        test_fill();
        test_stream();
        test_err_loop();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
